// File: rtl/perm_pkg.sv
// Shared types and helpers for the lexicographic permutation stepper.
// Holds the FSM state encoding, element-width helper and N limits.
package perm_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SWAP,
    REV,
    END
  } state_e;

  function automatic int perm_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/perm_suffix_sel.sv
// Picks the lowest suffix index below the pivot whose element exceeds
// the pivot element; the suffix is increasing, so this is the minimal one.
module perm_suffix_sel
  import perm_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = perm_w(N)
) (
  input  logic [N*W-1:0] perm,
  input  logic [W-1:0]   pivot,
  output logic [W-1:0]   q
);

  logic [W-1:0] piv_val;
  logic         found;

  always_comb begin
    piv_val = '0;
    for (int i = 0; i < N; i++) begin
      if (pivot == W'(i)) piv_val = perm[i*W +: W];
    end
  end

  always_comb begin
    q     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (W'(i) < pivot) &&
          (perm[i*W +: W] > piv_val)) begin
        q     = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/perm_stepper.sv
// Lexicographic next-permutation engine: scan / swap / reverse FSM.
// Define PERM_WRAP_EN to wrap to identity instead of flagging exhausted.
module perm_stepper
  import perm_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = perm_w(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           load,
  input  logic [N*W-1:0] perm_in,
  input  logic           next_req,
  output logic           busy,
  output logic           perm_valid,
  output logic [N*W-1:0] perm_out,
  output logic           exhausted,
  output logic           wrap
);

  state_e         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   pivot_q, pivot_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   q_sel;
  logic [W-1:0]   ptr_m1;
  logic [N*W-1:0] perm_q, perm_d;
  logic [N*W-1:0] ident;
  logic [N*W-1:0] rev_vec;
  logic           valid_q, valid_d;
  logic           exh_q, exh_d;
  logic           wrap_q, wrap_d;
  logic           scan_lt;
  logic           ptr_last;
  logic [W-1:0]   cur [N];
  logic [W-1:0]   sw  [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ident[i*W +: W] = W'(N - 1 - i);
      cur[W'(i)]      = perm_q[i*W +: W];
    end
  end

  assign ptr_m1   = ptr_q - W'(1);
  assign scan_lt  = cur[ptr_q] < cur[ptr_m1];
  assign ptr_last = (ptr_q == W'(N - 1));

  perm_suffix_sel #(
    .N (N)
  ) u_sel (
    .perm  (perm_q),
    .pivot (pivot_q),
    .q     (q_sel)
  );

  // perm_q stays stable until REV exit, so swap and reverse are one step
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sw[W'(i)] = cur[W'(i)];
    end
    sw[q_q]     = cur[pivot_q];
    sw[pivot_q] = cur[q_q];
    for (int i = 0; i < N; i++) begin
      if (W'(i) < pivot_q)
        rev_vec[i*W +: W] = sw[W'(int'(pivot_q) - 1 - i)];
      else
        rev_vec[i*W +: W] = sw[W'(i)];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pivot_q <= '0;
      q_q     <= '0;
      perm_q  <= ident;
      valid_q <= 1'b0;
      exh_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pivot_q <= pivot_d;
      q_q     <= q_d;
      perm_q  <= perm_d;
      valid_q <= valid_d;
      exh_q   <= exh_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (next_req) state_d = SCAN;
        SCAN: begin
          if (scan_lt)       state_d = SWAP;
          else if (ptr_last) state_d = END;
        end
        SWAP:    state_d = REV;
        REV:     state_d = IDLE;
        END:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    pivot_d = pivot_q;
    q_d     = q_q;
    perm_d  = perm_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    exh_d   = exh_q;
    if (load) begin
      perm_d = perm_in;
      exh_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (next_req) ptr_d = W'(1);
        SCAN: begin
          if (scan_lt)        pivot_d = ptr_q;
          else if (!ptr_last) ptr_d   = ptr_q + W'(1);
        end
        SWAP: q_d = q_sel;
        REV: begin
          perm_d  = rev_vec;
          valid_d = 1'b1;
        end
        END: begin
`ifdef PERM_WRAP_EN
          perm_d  = ident;
          valid_d = 1'b1;
          wrap_d  = 1'b1;
`else
          exh_d   = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign perm_valid = valid_q;
  assign perm_out   = perm_q;
  assign exhausted  = exh_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_perm_stepper.sv
// Directed self-checking bench for perm_stepper at N=3, N=4 and N=8.
// Expected values are hand-derived permutation encodings.
module tb_perm_stepper;

  logic clk = 1'b0;
  logic rst;

  logic        ld3, req3;
  logic [5:0]  in3, out3;
  logic        busy3, v3, ex3, wr3;

  logic        ld4, req4;
  logic [7:0]  in4, out4;
  logic        busy4, v4, ex4, wr4;

  logic        ld8, req8;
  logic [23:0] in8, out8;
  logic        busy8, v8, ex8, wr8;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [23:0] IDENT8 = 24'o01234567;
  localparam logic [23:0] FINAL8 = 24'o76543210;

  always #5 clk = ~clk;

  perm_stepper #(.N(3)) u3 (
    .CLK(clk), .RST(rst), .load(ld3), .perm_in(in3),
    .next_req(req3), .busy(busy3), .perm_valid(v3),
    .perm_out(out3), .exhausted(ex3), .wrap(wr3)
  );

  perm_stepper #(.N(4)) u4 (
    .CLK(clk), .RST(rst), .load(ld4), .perm_in(in4),
    .next_req(req4), .busy(busy4), .perm_valid(v4),
    .perm_out(out4), .exhausted(ex4), .wrap(wr4)
  );

  perm_stepper #(.N(8)) u8 (
    .CLK(clk), .RST(rst), .load(ld8), .perm_in(in8),
    .next_req(req8), .busy(busy8), .perm_valid(v8),
    .perm_out(out8), .exhausted(ex8), .wrap(wr8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_perm8(input logic [23:0] v);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[v[i*3 +: 3]] = 1'b1;
    return m == 8'hFF;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if (out3 !== 6'h06) begin
      n_bad++;
      $display("FAIL rst_out3: got %h want 06", out3);
    end
    n_cmp++;
    if (out4 !== 8'h1B) begin
      n_bad++;
      $display("FAIL rst_out4: got %h want 1b", out4);
    end
    n_cmp++;
    if (out8 !== IDENT8) begin
      n_bad++;
      $display("FAIL rst_out8: got %o want %o", out8, IDENT8);
    end
    n_cmp++;
    if ({busy3, v3, ex3, wr3, busy4, v4, ex4, wr4,
         busy8, v8, ex8, wr8} !== 12'h000) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 0",
               {busy3, v3, ex3, wr3, busy4, v4, ex4, wr4,
                busy8, v8, ex8, wr8});
    end
  endtask

  task automatic test_n3_seq();
    logic [5:0] exp_v [4];
    int         piv   [4];
    int         cnt;
    exp_v[0] = 6'h09; piv[0] = 1;
    exp_v[1] = 6'h12; piv[1] = 2;
    exp_v[2] = 6'h18; piv[2] = 1;
    exp_v[3] = 6'h21; piv[3] = 2;
    for (int k = 0; k < 4; k++) begin
      req3 = 1'b1;
      tick();
      req3 = 1'b0;
      n_cmp++;
      if (busy3 !== 1'b1) begin
        n_bad++;
        $display("FAIL n3_busy[%0d]: got %b want 1", k, busy3);
      end
      cnt = 0;
      while (!v3 && cnt < 20) begin
        tick();
        cnt++;
      end
      n_cmp++;
      if (cnt != piv[k] + 2) begin
        n_bad++;
        $display("FAIL n3_lat[%0d]: got %0d want %0d",
                 k, cnt, piv[k] + 2);
      end
      n_cmp++;
      if (out3 !== exp_v[k]) begin
        n_bad++;
        $display("FAIL n3_out[%0d]: got %h want %h",
                 k, out3, exp_v[k]);
      end
    end
  endtask

  task automatic test_n4_final();
    int seen;
    int wseen;
    ld4 = 1'b1;
    in4 = 8'hE4;
    tick();
    ld4 = 1'b0;
    n_cmp++;
    if (out4 !== 8'hE4) begin
      n_bad++;
      $display("FAIL n4_load: got %h want e4", out4);
    end
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    seen  = 0;
    wseen = 0;
    repeat (4) begin
      tick();
      if (v4) begin
        seen++;
        if (wr4) wseen++;
      end
    end
    n_cmp++;
    if (busy4 !== 1'b0) begin
      n_bad++;
      $display("FAIL n4_idle: got busy %b want 0", busy4);
    end
`ifdef PERM_WRAP_EN
    n_cmp++;
    if (seen != 1 || wseen != 1) begin
      n_bad++;
      $display("FAIL n4_wrap_pulse: got v=%0d w=%0d want 1/1",
               seen, wseen);
    end
    n_cmp++;
    if (out4 !== 8'h1B || ex4 !== 1'b0) begin
      n_bad++;
      $display("FAIL n4_wrap_out: got %h ex=%b want 1b ex=0",
               out4, ex4);
    end
`else
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL n4_no_valid: got %0d pulses want 0", seen);
    end
    n_cmp++;
    if (out4 !== 8'hE4 || ex4 !== 1'b1) begin
      n_bad++;
      $display("FAIL n4_exh: got %h ex=%b want e4 ex=1", out4, ex4);
    end
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (v4) seen++;
    end
    n_cmp++;
    if (seen != 0 || out4 !== 8'hE4 || ex4 !== 1'b1) begin
      n_bad++;
      $display("FAIL n4_rerun: got v=%0d %h ex=%b want 0 e4 1",
               seen, out4, ex4);
    end
`endif
    ld4 = 1'b1;
    in4 = 8'h1B;
    tick();
    ld4 = 1'b0;
    n_cmp++;
    if (ex4 !== 1'b0 || v4 !== 1'b0) begin
      n_bad++;
      $display("FAIL n4_load_clr: got ex=%b v=%b want 0 0", ex4, v4);
    end
  endtask

  task automatic test_n8_enum();
    logic [23:0] prev;
    int cnt, w, bad_ord, bad_perm;
    bit tmo;
    ld8 = 1'b1;
    in8 = 24'o70123456;
    tick();
    ld8 = 1'b0;
    prev     = out8;
    cnt      = 0;
    bad_ord  = 0;
    bad_perm = 0;
    tmo      = 1'b0;
    while (out8 !== FINAL8 && cnt < 5100 && !tmo) begin
      req8 = 1'b1;
      tick();
      req8 = 1'b0;
      w = 0;
      while (!v8 && w < 20) begin
        tick();
        w++;
      end
      if (!v8) begin
        tmo = 1'b1;
      end else begin
        cnt++;
        if (!(out8 > prev)) bad_ord++;
        if (!is_perm8(out8)) bad_perm++;
        prev = out8;
      end
    end
    n_cmp++;
    if (tmo) begin
      n_bad++;
      $display("FAIL n8_timeout: no perm_valid after %0d steps", cnt);
    end
    n_cmp++;
    if (cnt != 5039) begin
      n_bad++;
      $display("FAIL n8_count: got %0d want 5039", cnt);
    end
    n_cmp++;
    if (bad_ord != 0 || bad_perm != 0) begin
      n_bad++;
      $display("FAIL n8_order: got %0d bad order %0d bad perm want 0",
               bad_ord, bad_perm);
    end
    n_cmp++;
    if (out8 !== FINAL8) begin
      n_bad++;
      $display("FAIL n8_last: got %o want %o", out8, FINAL8);
    end
  endtask

  task automatic test_load_abort();
    int vseen;
    req8 = 1'b1;
    tick();
    req8 = 1'b0;
    tick();
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_busy: got %b want 1", busy8);
    end
    ld8 = 1'b1;
    in8 = IDENT8;
    tick();
    ld8 = 1'b0;
    n_cmp++;
    if (busy8 !== 1'b0 || v8 !== 1'b0 || out8 !== IDENT8) begin
      n_bad++;
      $display("FAIL abort_idle: got b=%b v=%b %o want 0 0 %o",
               busy8, v8, out8, IDENT8);
    end
    vseen = 0;
    repeat (12) begin
      tick();
      if (v8) vseen++;
    end
    n_cmp++;
    if (vseen != 0 || ex8 !== 1'b0 || wr8 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet: got v=%0d ex=%b w=%b want 0 0 0",
               vseen, ex8, wr8);
    end
  endtask

  task automatic test_busy_ignore();
    int vcnt;
    req8 = 1'b1;
    tick();
    vcnt = 0;
    repeat (3) begin
      tick();
      if (v8) vcnt++;
    end
    req8 = 1'b0;
    repeat (10) begin
      tick();
      if (v8) vcnt++;
    end
    n_cmp++;
    if (vcnt != 1) begin
      n_bad++;
      $display("FAIL busy_ign_cnt: got %0d want 1", vcnt);
    end
    n_cmp++;
    if (out8 !== 24'o01234576) begin
      n_bad++;
      $display("FAIL busy_ign_out: got %o want 01234576", out8);
    end
  endtask

  task automatic test_rst_mid_rev();
    req8 = 1'b1;
    tick();
    req8 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy8 !== 1'b1 || v8 !== 1'b0) begin
      n_bad++;
      $display("FAIL rev_state: got b=%b v=%b want 1 0", busy8, v8);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out8 !== IDENT8 || {busy8, v8, ex8, wr8} !== 4'h0) begin
      n_bad++;
      $display("FAIL rev_rst: got %o flags %b want %o 0000",
               out8, {busy8, v8, ex8, wr8}, IDENT8);
    end
  endtask

  initial begin
    rst  = 1'b1;
    ld3  = 1'b0; req3 = 1'b0; in3 = '0;
    ld4  = 1'b0; req4 = 1'b0; in4 = '0;
    ld8  = 1'b0; req8 = 1'b0; in8 = '0;
    test_reset();
    test_n3_seq();
    test_n4_final();
    test_n8_enum();
    test_load_abort();
    test_busy_ignore();
    test_rst_mid_rev();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
